// File: rtl/hazard_unit.sv
// hazard_unit: 5-stage ARM pipeline hazard detection, forwarding and perf counters
// Ports:
//   clk, reset                 core clock, async active-high reset
//   RA1D/RA2D, RA1E/RA2E       D/E-stage source register numbers
//   WA3E/WA3M/WA3W             E/M/W destination register numbers
//   RegWriteM/RegWriteW        gated write enables from the controller
//   MemtoRegE                  E-stage instruction is a load
//   BranchTakenE               branch resolved taken in E
//   PCSrcW, PCWrPendingF       PC write retiring / pending
//   cnt_clr                    sync clear of counters and hang_err
//   ForwardAE/ForwardBE        00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/StallD/FlushD/FlushE pipeline control
//   ldr_stall_cnt/pc_stall_cnt/flush_cnt  saturating perf counters
//   hang_err                   sticky stall-streak watchdog flag
module hazard_unit #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             PCSrcW,
    input  logic             PCWrPendingF,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] ldr_stall_cnt,
    output logic [CNT_W-1:0] pc_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang_err
);
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam logic [SW-1:0] MAXS = SW'(MAX_STALL);
    localparam logic [CNT_W-1:0] SAT = '1;

    logic          ldrStall;
    logic [SW-1:0] streak;

    // M stage is newer than W, so it wins when both match
    always_comb begin
        ForwardAE = (RegWriteM && RA1E == WA3M) ? 2'b10 :
                    (RegWriteW && RA1E == WA3W) ? 2'b01 : 2'b00;
        ForwardBE = (RegWriteM && RA2E == WA3M) ? 2'b10 :
                    (RegWriteW && RA2E == WA3W) ? 2'b01 : 2'b00;
        ldrStall  = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        StallF    = ldrStall || PCWrPendingF;
        StallD    = ldrStall;
        FlushD    = PCWrPendingF || PCSrcW || BranchTakenE;
        FlushE    = ldrStall || BranchTakenE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ldr_stall_cnt <= '0;
            pc_stall_cnt  <= '0;
            flush_cnt     <= '0;
            streak        <= '0;
            hang_err      <= 1'b0;
        end else begin
            // streak is the watchdog's view of the pipeline, not a statistic,
            // so the counter clear leaves it alone
            streak <= !StallF ? '0 : (streak == MAXS) ? streak : streak + 1'b1;
            if (cnt_clr) begin
                ldr_stall_cnt <= '0;
                pc_stall_cnt  <= '0;
                flush_cnt     <= '0;
                hang_err      <= 1'b0;
            end else begin
                if (ldrStall && ldr_stall_cnt != SAT)
                    ldr_stall_cnt <= ldr_stall_cnt + 1'b1;
                // a load-use stall cycle is attributed only to the ldr counter
                if (PCWrPendingF && !ldrStall && pc_stall_cnt != SAT)
                    pc_stall_cnt <= pc_stall_cnt + 1'b1;
                if (BranchTakenE && flush_cnt != SAT)
                    flush_cnt <= flush_cnt + 1'b1;
                if (StallF && streak == MAXS)
                    hang_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCSrcW, PCWrPendingF, cnt_clr;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, hang_err;
    logic [3:0] ldr_stall_cnt, pc_stall_cnt, flush_cnt;
    int         nCmp = 0;
    int         nErr = 0;

    hazard_unit #(.CNT_W(4), .MAX_STALL(8)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF),
        .cnt_clr(cnt_clr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ldr_stall_cnt(ldr_stall_cnt), .pc_stall_cnt(pc_stall_cnt), .flush_cnt(flush_cnt),
        .hang_err(hang_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCSrcW, PCWrPendingF, cnt_clr} = '0;
    endtask

    task automatic chkCnt(input string tag, input int l, input int p, input int f);
        chk({tag, "_ldr"}, 32'(ldr_stall_cnt), 32'(l));
        chk({tag, "_pc"}, 32'(pc_stall_cnt), 32'(p));
        chk({tag, "_flush"}, 32'(flush_cnt), 32'(f));
    endtask

    initial begin
        clearIn();
        #2;
        chkCnt("reset", 0, 0, 0);
        chk("reset_hang", 32'(hang_err), 0);
        chk("reset_fwdA", 32'(ForwardAE), 0);
        #10 reset = 1'b0;
        tick();
        chkCnt("idle", 0, 0, 0);

        // forwarding
        RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1; #1;
        chk("fwdA_M", 32'(ForwardAE), 2);
        RegWriteM = 0; #1;
        chk("fwdA_W", 32'(ForwardAE), 1);
        RA2E = 5; #1;
        chk("fwdB_none", 32'(ForwardBE), 0);
        RA2E = 3; #1;
        chk("fwdB_W", 32'(ForwardBE), 1);
        RA2E = 7; WA3M = 7; RegWriteM = 1; #1;
        chk("fwdB_M", 32'(ForwardBE), 2);
        chk("fwdA_W2", 32'(ForwardAE), 1);
        RA1E = 15; WA3M = 15; WA3W = 15; #1;
        chk("fwdA_r15", 32'(ForwardAE), 2);
        clearIn(); tick();

        // load-use
        MemtoRegE = 1; WA3E = 2; RA2D = 2; RA1D = 1; #1;
        chk("lu_stallF", 32'(StallF), 1);
        chk("lu_stallD", 32'(StallD), 1);
        chk("lu_flushE", 32'(FlushE), 1);
        chk("lu_flushD", 32'(FlushD), 0);
        tick();
        chkCnt("lu", 1, 0, 0);
        clearIn(); tick();

        // branch then pending PC write
        BranchTakenE = 1; #1;
        chk("br_flushD", 32'(FlushD), 1);
        chk("br_flushE", 32'(FlushE), 1);
        chk("br_stallF", 32'(StallF), 0);
        tick();
        chkCnt("br", 1, 0, 1);
        clearIn();
        PCWrPendingF = 1; #1;
        chk("pcw_stallF", 32'(StallF), 1);
        chk("pcw_stallD", 32'(StallD), 0);
        chk("pcw_flushD", 32'(FlushD), 1);
        repeat (3) tick();
        chkCnt("pcw", 1, 3, 1);
        clearIn();
        PCSrcW = 1; #1;
        chk("pcsrc_flushD", 32'(FlushD), 1);
        chk("pcsrc_flushE", 32'(FlushE), 0);
        clearIn(); tick();

        // simultaneous load-use and branch
        MemtoRegE = 1; WA3E = 2; RA1D = 2; RA2D = 9; BranchTakenE = 1; #1;
        chk("sim_stallD", 32'(StallD), 1);
        chk("sim_flushD", 32'(FlushD), 1);
        chk("sim_flushE", 32'(FlushE), 1);
        tick();
        chkCnt("sim", 2, 3, 2);
        // load-use during pending PC write counts only as ldr
        BranchTakenE = 0; PCWrPendingF = 1;
        tick();
        chkCnt("ldr_pcw", 3, 3, 2);
        clearIn(); tick();

        // saturation: 20 load-use cycles from 3 -> 15; streak trips watchdog too
        MemtoRegE = 1; WA3E = 4; RA1D = 4;
        repeat (20) tick();
        chkCnt("sat", 15, 3, 2);
        chk("sat_hang", 32'(hang_err), 1);
        clearIn(); cnt_clr = 1;
        tick();
        chkCnt("clr", 0, 0, 0);
        chk("clr_hang", 32'(hang_err), 0);
        cnt_clr = 0;

        // watchdog
        PCWrPendingF = 1;
        repeat (8) tick();
        chk("wd_8", 32'(hang_err), 0);
        tick();
        chk("wd_9", 32'(hang_err), 1);
        chk("wd_pc", 32'(pc_stall_cnt), 9);
        PCWrPendingF = 0;
        tick();
        chk("wd_sticky", 32'(hang_err), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_hang", 32'(hang_err), 0);
        chkCnt("async", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_hang", 32'(hang_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard unit for the 5-stage ARM core. Consumes the controller's writeback/pending/branch status and the datapath's register addresses.
- Produces forwarding selects, stall and flush controls, including FlushE, which feeds the controller's E-stage register clear.
- Also keeps saturating hazard performance counters and a stall-streak watchdog for bring-up and debug.

Parameters:
- CNT_W, 16, width of each performance counter.
- MAX_STALL, 8, consecutive StallF cycles allowed before hang_err sets.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- RA1D, RA2D  in  4 each  D-stage source register numbers.
- RA1E, RA2E  in  4 each  E-stage source register numbers.
- WA3E, WA3M, WA3W  in  4 each  destination register numbers in E/M/W.
- RegWriteM, RegWriteW  in  1 each  gated register-write enables from the controller.
- MemtoRegE  in  1  E-stage instruction is a load.
- BranchTakenE  in  1  branch resolved taken in E.
- PCSrcW  in  1  PC write retiring in W.
- PCWrPendingF  in  1  PC write pending in D/E/M.
- cnt_clr  in  1  synchronous clear of counters and hang_err.
- ForwardAE, ForwardBE  out  2 each  SrcA/SrcB select: 00 = register file, 01 = ResultW, 10 = ALUOutM.
- StallF, StallD  out  1 each  hold PC / hold IF-ID register.
- FlushD, FlushE  out  1 each  clear IF-ID / clear ID-EX register.
- ldr_stall_cnt, pc_stall_cnt, flush_cnt  out  CNT_W each  performance counters.
- hang_err  out  1  sticky watchdog flag.

Behaviour:
- Hazard outputs are combinational, with zero latency.
- Forwarding, per operand X in {A, B} using RA1E / RA2E respectively:
  - 10 if RAxE == WA3M and RegWriteM.
  - Otherwise 01 if RAxE == WA3W and RegWriteW.
  - Otherwise 00.
  - M has priority over W when both match.
  - No special case for R15: the register number is compared like any other.
- LDRstall = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E)).
- Control equations:
  - StallF = LDRstall | PCWrPendingF.
  - StallD = LDRstall.
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenE.
  - FlushE = LDRstall | BranchTakenE.
- During reset, combinational outputs follow their equations with no reset override. The controller's own reset clears the pipeline state that drives them.
- Counters update at clk rising edge. All reset asynchronously to 0; cnt_clr forces all to 0 (cnt_clr wins over increments).
  - ldr_stall_cnt increments each cycle LDRstall = 1.
  - pc_stall_cnt increments each cycle PCWrPendingF = 1 and LDRstall = 0, so no cycle counts in both.
  - flush_cnt increments each cycle BranchTakenE = 1.
  - All counters saturate at 2^CNT_W − 1 and never wrap.
- Watchdog:
  - streak register, width clog2(MAX_STALL+1), reset 0.
  - StallF = 1: streak <= min(streak + 1, MAX_STALL). StallF = 0: streak <= 0.
  - hang_err sets on the edge where streak == MAX_STALL and StallF = 1, i.e. on the (MAX_STALL+1)th consecutive stall cycle.
  - hang_err is sticky until reset or cnt_clr.
- Simultaneous LDRstall and BranchTakenE: FlushE = 1, StallD = 1, FlushD = 1. Flush dominates in the downstream registers; both the ldr and flush counters increment.
- Reset asserted mid-operation: all counters, streak and hang_err clear immediately (asynchronously), independent of clk.

Test Plan:
- Forwarding: RA1E = 3, WA3M = 3, RegWriteM = 1, WA3W = 3, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Then RA2E = 5, no match -> ForwardBE = 00.
- Load-use: MemtoRegE = 1, WA3E = 2, RA2D = 2 for 1 cycle -> StallF = StallD = FlushE = 1, FlushD = 0; ldr_stall_cnt goes 0 -> 1.
- Branch: BranchTakenE = 1 for 1 cycle -> FlushD = FlushE = 1, StallF = 0; flush_cnt = 1. Then PCWrPendingF = 1 for 3 cycles -> pc_stall_cnt = 3, ldr_stall_cnt unchanged.
- Saturation: CNT_W = 4, LDRstall held 20 cycles -> ldr_stall_cnt reaches 15 and stays. Pulse cnt_clr -> all counters 0 next edge.
- Watchdog: PCWrPendingF held 8 cycles -> hang_err = 0. 9th cycle -> hang_err = 1. Deassert -> stays 1. Async reset pulse mid-cycle -> hang_err = 0 immediately.
- Simultaneous: LDRstall and BranchTakenE together -> StallD = FlushD = FlushE = 1; ldr_stall_cnt and flush_cnt each +1.
